// File: rtl/bp_fe_pkg.sv
// Front-end shared types: pre-decode record for one instruction slot, link-register
// constants and processor configuration lookup.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_sv32_cfg
    } bp_params_e;

    localparam int scan_imm_width_gp = 21;
    localparam logic [4:0] reg_ra_gp = 5'd1;
    localparam logic [4:0] reg_t0_gp = 5'd5;

    // branch/jal/jalr sit in the top three bits so control-flow can be tested by slicing
    typedef struct packed {
        logic                         branch;
        logic                         jal;
        logic                         jalr;
        logic                         call;
        logic                         ret;
        logic [scan_imm_width_gp-1:0] imm;
    } bp_fe_instr_scan_s;

    function automatic int proc_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_sv32_cfg: return 32;
            default:       return 39;
        endcase
    endfunction

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == reg_ra_gp) || (r == reg_t0_gp);
    endfunction

endpackage

`ifndef BP_FE_INSTR_SCAN_WIDTH
`define BP_FE_INSTR_SCAN_WIDTH(vaddr_width_mp) ($bits(bp_fe_pkg::bp_fe_instr_scan_s))
`endif

// File: rtl/bp_fe_instr_scan_block_decode.sv
// Combinational control-flow classifier for one instruction slot (32b or RVC in the low half).
// Compressed decode is present only when BP_FE_SCAN_RVC_EN is defined.
module bp_fe_instr_scan_decode
    import bp_fe_pkg::*;
(
    input  logic [31:0]                           instr,
    output logic [$bits(bp_fe_instr_scan_s)-1:0]  scan
);

    bp_fe_instr_scan_s scan_32;
    bp_fe_instr_scan_s scan_sel;

    always_comb begin
        scan_32 = '0;
        case (instr[6:0])
            7'b1100011: begin
                scan_32.branch = 1'b1;
                scan_32.imm    = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b1101111: begin
                scan_32.jal  = 1'b1;
                scan_32.call = is_link_reg(instr[11:7]);
                scan_32.imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b1100111: begin
                if (instr[14:12] == 3'b000) begin
                    scan_32.jalr = 1'b1;
                    scan_32.call = is_link_reg(instr[11:7]);
                    scan_32.ret  = is_link_reg(instr[19:15]) && (instr[11:7] != instr[19:15]);
                    scan_32.imm  = {{9{instr[31]}}, instr[31:20]};
                end
            end
            default: ;
        endcase
    end

`ifdef BP_FE_SCAN_RVC_EN
    bp_fe_instr_scan_s scan_16;
    logic [4:0]        c_rd;

    always_comb begin
        scan_16 = '0;
        c_rd    = instr[12] ? reg_ra_gp : 5'd0;
        if (instr[1:0] == 2'b01 && instr[15:13] == 3'b101) begin
            scan_16.jal = 1'b1;
            scan_16.imm = {{9{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                           instr[2], instr[11], instr[5:3], 1'b0};
        end else if (instr[1:0] == 2'b01 && instr[15:14] == 2'b11) begin
            scan_16.branch = 1'b1;
            scan_16.imm    = {{12{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                              instr[4:3], 1'b0};
        end else if (instr[1:0] == 2'b10 && instr[15:13] == 3'b100
                     && instr[6:2] == 5'd0 && instr[11:7] != 5'd0) begin
            // rs1==x0 with rs2==x0 is C.EBREAK / reserved, never a jump
            scan_16.jalr = 1'b1;
            scan_16.call = instr[12];
            scan_16.ret  = is_link_reg(instr[11:7]) && (c_rd != instr[11:7]);
        end
    end

    assign scan_sel = (instr[1:0] != 2'b11) ? scan_16 : scan_32;
`else
    assign scan_sel = scan_32;
`endif

    assign scan = scan_sel;

endmodule

// File: rtl/bp_fe_instr_scan_block.sv
// Fetch-block scanner: splits a block of 16b parcels into instruction slots, carries a straddling
// 32b instruction into the next block, and registers the result. RVC support via BP_FE_SCAN_RVC_EN.
module bp_fe_instr_scan_block
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         fetch_parcels_p = 4,
    localparam int        vaddr_width_p   = proc_vaddr_width(bp_params_p),
    localparam int        pidx_lp         = $clog2(fetch_parcels_p),
    localparam int        scan_width_lp   = `BP_FE_INSTR_SCAN_WIDTH(vaddr_width_p)
)
(
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      redirect_i,
    input  logic                                      fetch_v_i,
    output logic                                      fetch_ready_and_o,
    input  logic [vaddr_width_p-1:0]                  fetch_pc_i,
    input  logic [16*fetch_parcels_p-1:0]             fetch_data_i,
    output logic                                      scan_v_o,
    input  logic                                      scan_ready_and_i,
    output logic [fetch_parcels_p-1:0]                slot_v_o,
    output logic [fetch_parcels_p*vaddr_width_p-1:0]  slot_pc_o,
    output logic [fetch_parcels_p-1:0]                slot_rvc_o,
    output logic [fetch_parcels_p*scan_width_lp-1:0]  slot_scan_o,
    output logic                                      first_cf_v_o,
    output logic [pidx_lp-1:0]                        first_cf_idx_o
);

`ifdef BP_FE_SCAN_RVC_EN
    localparam logic rvc_en_lp = 1'b1;
`else
    localparam logic rvc_en_lp = 1'b0;
`endif
    localparam int P = fetch_parcels_p;
    localparam logic [vaddr_width_p-1:0] blk_mask_lp = ~vaddr_width_p'(2*P - 1);

    logic [15:0]               parcel      [P];
    logic [15:0]               parcel_next [P];
    logic [31:0]               slot_instr_next [P];
    logic [vaddr_width_p-1:0]  slot_pc_next    [P];
    logic [scan_width_lp-1:0]  scan_raw        [P];
    logic [P-1:0]              slot_v_next, slot_rvc_next, slot_cf_next;
    logic [P*vaddr_width_p-1:0] slot_pc_flat_next;
    logic [P*scan_width_lp-1:0] slot_scan_flat_next;

    logic                      scan_v_reg;
    logic [P-1:0]              slot_v_reg, slot_rvc_reg, slot_cf_reg;
    logic [P*vaddr_width_p-1:0] slot_pc_reg;
    logic [P*scan_width_lp-1:0] slot_scan_reg;
    logic                      carry_v_reg, carry_v_next;
    logic [vaddr_width_p-1:0]  carry_pc_reg, carry_pc_next;
    logic [15:0]               carry_parcel_reg, carry_parcel_next;

    logic [pidx_lp-1:0]        start;
    logic [vaddr_width_p-1:0]  base_pc;
    logic                      carry_hit, live_en, accept, skip;

    assign start     = fetch_pc_i[1 +: pidx_lp];
    assign base_pc   = fetch_pc_i & blk_mask_lp;
    assign carry_hit = carry_v_reg && (start == '0)
                       && (fetch_pc_i == carry_pc_reg + vaddr_width_p'(2));
    // without RVC a half-word-aligned PC cannot begin any 32b slot in this block
    assign live_en   = rvc_en_lp | ~fetch_pc_i[1];

    assign fetch_ready_and_o = ~redirect_i & (~scan_v_reg | scan_ready_and_i);
    assign accept            = fetch_v_i & fetch_ready_and_o;

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_parcel
            assign parcel[gi]      = fetch_data_i[16*gi +: 16];
            assign parcel_next[gi] = fetch_data_i[16*((gi+1) % P) +: 16];
        end
    endgenerate

    always_comb begin
        skip              = 1'b0;
        carry_v_next      = 1'b0;
        carry_pc_next     = carry_pc_reg;
        carry_parcel_next = carry_parcel_reg;
        for (int i = 0; i < P; i++) begin
            slot_v_next[i]     = 1'b0;
            slot_rvc_next[i]   = 1'b0;
            slot_instr_next[i] = {16'h0000, parcel[i]};
            slot_pc_next[i]    = base_pc | vaddr_width_p'(2*i);
            if (i == 0 && carry_hit) begin
                slot_v_next[i]     = 1'b1;
                slot_instr_next[i] = {parcel[0], carry_parcel_reg};
                slot_pc_next[i]    = carry_pc_reg;
            end else if (skip) begin
                skip = 1'b0;
            end else if (live_en && i >= int'(start)) begin
                if (rvc_en_lp && parcel[i][1:0] != 2'b11) begin
                    slot_v_next[i]   = 1'b1;
                    slot_rvc_next[i] = 1'b1;
                end else if (i < P-1) begin
                    slot_v_next[i]     = 1'b1;
                    slot_instr_next[i] = {parcel_next[i], parcel[i]};
                    skip               = 1'b1;
                end else begin
                    carry_v_next      = rvc_en_lp;
                    carry_pc_next     = slot_pc_next[i];
                    carry_parcel_next = parcel[i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_slot
            bp_fe_instr_scan_decode u_decode (
                .instr (slot_instr_next[gi]),
                .scan  (scan_raw[gi])
            );
            assign slot_pc_flat_next[gi*vaddr_width_p +: vaddr_width_p] = slot_pc_next[gi];
            assign slot_scan_flat_next[gi*scan_width_lp +: scan_width_lp] =
                slot_v_next[gi] ? scan_raw[gi] : '0;
            assign slot_cf_next[gi] = slot_v_next[gi] & (|scan_raw[gi][scan_width_lp-1 -: 3]);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scan_v_reg       <= 1'b0;
            slot_v_reg       <= '0;
            slot_rvc_reg     <= '0;
            slot_cf_reg      <= '0;
            slot_pc_reg      <= '0;
            slot_scan_reg    <= '0;
            carry_v_reg      <= 1'b0;
            carry_pc_reg     <= '0;
            carry_parcel_reg <= '0;
        end else if (redirect_i) begin
            scan_v_reg  <= 1'b0;
            carry_v_reg <= 1'b0;
        end else if (accept) begin
            scan_v_reg       <= 1'b1;
            slot_v_reg       <= slot_v_next;
            slot_rvc_reg     <= slot_rvc_next;
            slot_cf_reg      <= slot_cf_next;
            slot_pc_reg      <= slot_pc_flat_next;
            slot_scan_reg    <= slot_scan_flat_next;
            carry_v_reg      <= carry_v_next;
            carry_pc_reg     <= carry_pc_next;
            carry_parcel_reg <= carry_parcel_next;
        end else if (scan_ready_and_i) begin
            scan_v_reg <= 1'b0;
        end
    end

    always_comb begin
        first_cf_v_o   = 1'b0;
        first_cf_idx_o = '0;
        for (int i = P-1; i >= 0; i--) begin
            if (slot_cf_reg[i]) begin
                first_cf_v_o   = 1'b1;
                first_cf_idx_o = pidx_lp'(i);
            end
        end
    end

    assign scan_v_o    = scan_v_reg;
    assign slot_v_o    = slot_v_reg;
    assign slot_rvc_o  = slot_rvc_reg;
    assign slot_pc_o   = slot_pc_reg;
    assign slot_scan_o = slot_scan_reg;

endmodule
